dct_z5_da_accumulator: RTL and testbench

Bit-serial distributed-arithmetic (DA) engine for the Z5 DCT output. It sits directly downstream of the Z5 coefficient ROM. It accepts four signed samples x0..x3 on a valid/ready handshake and walks their bits LSB-first, driving the ROM chip-select and 3-bit address. It shift-accumulates the 16-bit ROM words into one full-precision Z5 result, which it holds on a valid/ready output port.

---
 rtl/dct_z5_da_accumulator.sv | 108 ++++++++++
 tb/tb_dct_z5_da_accumulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dct_z5_da_accumulator.sv
// Bit-serial distributed-arithmetic accumulator for the Z5 DCT output.
// Walks four samples LSB-first through a folded 8-entry coefficient ROM.
module dct_z5_da_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16 + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    output logic                     rom_cs,
    output logic [2:0]               rom_addr,
    input  logic signed [15:0]       rom_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;
    localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_W - 1);

    logic [1:0]              state_q, state_d;
    logic [DATA_W-1:0]       sr0_q, sr0_d, sr1_q, sr1_d, sr2_q, sr2_d, sr3_q, sr3_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]              slice;
    logic                    x0j;
    logic                    last_bit;
    logic signed [ACC_W-1:0] rom_ext, term, term_sh;

    always_comb begin
        slice     = {sr1_q[0], sr2_q[0], sr3_q[0]};
        x0j       = sr0_q[0];
        last_bit  = (bit_cnt_q == LastBit);
        in_ready  = (state_q == StIdle);
        rom_cs    = (state_q == StRun);
        out_valid = (state_q == StDone);
        out_data  = acc_q;
        // Folded table: x0j=1 reads the complementary entry and negates it.
        rom_addr  = rom_cs ? (x0j ? ~slice : slice) : 3'b000;
        rom_ext   = {{(ACC_W-16){rom_data[15]}}, rom_data};
        term      = x0j ? -rom_ext : rom_ext;
        term_sh   = term <<< bit_cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        sr0_d     = sr0_q;
        sr1_d     = sr1_q;
        sr2_d     = sr2_q;
        sr3_d     = sr3_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sr0_d     = x0;
                    sr1_d     = x1;
                    sr2_d     = x2;
                    sr3_d     = x3;
                    acc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                // Sign bit carries negative weight in two's complement.
                acc_d     = last_bit ? (acc_q - term_sh) : (acc_q + term_sh);
                sr0_d     = sr0_q >> 1;
                sr1_d     = sr1_q >> 1;
                sr2_d     = sr2_q >> 1;
                sr3_d     = sr3_q >> 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (last_bit) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sr0_q     <= '0;
            sr1_q     <= '0;
            sr2_q     <= '0;
            sr3_q     <= '0;
            acc_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr0_q     <= sr0_d;
            sr1_q     <= sr1_d;
            sr2_q     <= sr2_d;
            sr3_q     <= sr3_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: tb/tb_dct_z5_da_accumulator.sv
// Directed bench for the Z5 DA accumulator with a behavioural folded ROM.
module tb_dct_z5_da_accumulator;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16 + DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [DATA_W-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic rom_cs;
    logic [2:0] rom_addr;
    logic signed [15:0] rom_data;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [ACC_W-1:0] out_data;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic signed [ACC_W-1:0] exp_data;
    logic signed [15:0] rom_tab [8];

    always #5 clk = ~clk;

    // Folded half table of 0.5*(-c0 +/- c1 +/- c2 +/- c3), c = {-13622, 11585, 1288, -9103}.
    initial begin
        rom_tab[0] = 16'sd4926;   rom_tab[1] = -16'sd4177;
        rom_tab[2] = 16'sd6214;   rom_tab[3] = -16'sd2889;
        rom_tab[4] = 16'sd16511;  rom_tab[5] = 16'sd7408;
        rom_tab[6] = 16'sd17799;  rom_tab[7] = 16'sd8696;
    end

    always_comb rom_data = rom_cs ? rom_tab[rom_addr] : 16'sd0;

    dct_z5_da_accumulator #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Offset-binary DA result equals sum(c_i*x_i) + 0.5*sum(c_i).
    function automatic logic signed [ACC_W-1:0] ref_model(input logic signed [7:0] a, b, c, d);
        int r;
        r = -13622 * int'(a) + 11585 * int'(b) + 1288 * int'(c) - 9103 * int'(d) - 4926;
        return ACC_W'(r);
    endfunction

    // Presents one set for a single cycle; returns at the negedge of RUN bit 0.
    task automatic start_set(input logic signed [7:0] a, b, c, d);
        @(negedge clk);
        x0 = a; x1 = b; x2 = c; x3 = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_data !== '0) $display("FAIL reset_out_data: got %0d expected 0", out_data); else pass_cnt++;
        chk_cnt++; if (rom_cs !== 1'b0 || rom_addr !== 3'b000)
            $display("FAIL reset_rom: got cs=%b addr=%b expected cs=0 addr=000", rom_cs, rom_addr); else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero();
        start_set(8'sd0, 8'sd0, 8'sd0, 8'sd0);
        for (int k = 0; k < DATA_W; k++) begin
            chk_cnt++; if (rom_cs !== 1'b1 || rom_addr !== 3'b000)
                $display("FAIL zero_bit%0d: got cs=%b addr=%b expected cs=1 addr=000", k, rom_cs, rom_addr);
            else pass_cnt++;
            @(negedge clk);
        end
        exp_data = -24'sd4926;
        chk_cnt++; if (out_valid !== 1'b1 || out_data !== exp_data)
            $display("FAIL zero_out: got valid=%b data=%0d expected valid=1 data=%0d", out_valid, out_data, exp_data);
        else pass_cnt++;
        chk_cnt++; if (rom_cs !== 1'b0 || rom_addr !== 3'b000)
            $display("FAIL zero_rom_done: got cs=%b addr=%b expected cs=0 addr=000", rom_cs, rom_addr); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL zero_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_x0_neg();
        int bad = 0;
        start_set(-8'sd1, 8'sd0, 8'sd0, 8'sd0);
        for (int k = 0; k < DATA_W; k++) begin
            if (rom_addr !== 3'b111) bad++;
            @(negedge clk);
        end
        chk_cnt++; if (bad != 0) $display("FAIL x0neg_addr: got %0d bad bits expected 0", bad); else pass_cnt++;
        exp_data = 24'sd8696;
        chk_cnt++; if (out_valid !== 1'b1 || out_data !== exp_data)
            $display("FAIL x0neg_out: got valid=%b data=%0d expected valid=1 data=%0d", out_valid, out_data, exp_data);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_x3_one();
        int bad = 0;
        start_set(8'sd0, 8'sd0, 8'sd0, 8'sd1);
        chk_cnt++; if (rom_addr !== 3'b001 || rom_data !== -16'sd4177)
            $display("FAIL x3one_bit0: got addr=%b data=%0d expected addr=001 data=-4177", rom_addr, rom_data);
        else pass_cnt++;
        @(negedge clk);
        for (int k = 1; k < DATA_W; k++) begin
            if (rom_addr !== 3'b000) bad++;
            @(negedge clk);
        end
        chk_cnt++; if (bad != 0) $display("FAIL x3one_addr: got %0d bad bits expected 0", bad); else pass_cnt++;
        exp_data = -24'sd14029;
        chk_cnt++; if (out_valid !== 1'b1 || out_data !== exp_data)
            $display("FAIL x3one_out: got valid=%b data=%0d expected valid=1 data=%0d", out_valid, out_data, exp_data);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start_set(8'sd5, -8'sd3, 8'sd7, -8'sd128);
        repeat (DATA_W) @(negedge clk);
        exp_data = ref_model(8'sd5, -8'sd3, 8'sd7, -8'sd128);
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (out_valid !== 1'b1 || out_data !== exp_data || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got valid=%b data=%0d ready=%b expected valid=1 data=%0d ready=0",
                         i, out_valid, out_data, in_ready, exp_data);
            else pass_cnt++;
            x0 = 8'sd99; x1 = 8'sd1; x2 = -8'sd7; x3 = 8'sd42;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk_cnt++; if (out_valid !== 1'b1 || out_data !== exp_data)
            $display("FAIL bp_release: got valid=%b data=%0d expected valid=1 data=%0d", out_valid, out_data, exp_data);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); else pass_cnt++;
        start_set(-8'sd100, 8'sd127, -8'sd1, 8'sd64);
        repeat (DATA_W) @(negedge clk);
        exp_data = ref_model(-8'sd100, 8'sd127, -8'sd1, 8'sd64);
        chk_cnt++; if (out_valid !== 1'b1 || out_data !== exp_data)
            $display("FAIL bp_next: got valid=%b data=%0d expected valid=1 data=%0d", out_valid, out_data, exp_data);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        start_set(8'sd85, -8'sd86, 8'sd3, 8'sd17);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++; if (in_ready !== 1'b1 || rom_cs !== 1'b0 || rom_addr !== 3'b000 || out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL midrst_idle: got ready=%b cs=%b addr=%b valid=%b data=%0d expected 1 0 000 0 0",
                     in_ready, rom_cs, rom_addr, out_valid, out_data);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        chk_cnt++; if (seen != 0) $display("FAIL midrst_no_valid: got %0d valid cycles expected 0", seen); else pass_cnt++;
        start_set(8'sd0, 8'sd0, 8'sd0, 8'sd0);
        repeat (DATA_W) @(negedge clk);
        exp_data = -24'sd4926;
        chk_cnt++; if (out_valid !== 1'b1 || out_data !== exp_data)
            $display("FAIL midrst_after: got valid=%b data=%0d expected valid=1 data=%0d", out_valid, out_data, exp_data);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic signed [7:0] sa [3], sb [3], sc [3], sd [3];
        logic signed [ACC_W-1:0] exp_q [3];
        int acc_cyc [3];
        int sent = 0;
        int got = 0;
        for (int i = 0; i < 3; i++) begin
            sa[i] = 8'($urandom); sb[i] = 8'($urandom); sc[i] = 8'($urandom); sd[i] = 8'($urandom);
            exp_q[i] = ref_model(sa[i], sb[i], sc[i], sd[i]);
            acc_cyc[i] = 0;
        end
        @(negedge clk);
        x0 = sa[0]; x1 = sb[0]; x2 = sc[0]; x3 = sd[0];
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 120 && got < 3; cyc++) begin
            if (out_valid === 1'b1) begin
                chk_cnt++; if (out_data !== exp_q[got])
                    $display("FAIL b2b_out%0d: got %0d expected %0d", got, out_data, exp_q[got]);
                else pass_cnt++;
                got++;
            end
            if (in_ready === 1'b1 && in_valid && sent < 3) begin
                acc_cyc[sent] = cyc;
                sent++;
                @(posedge clk);
                #1;
                if (sent < 3) begin
                    x0 = sa[sent]; x1 = sb[sent]; x2 = sc[sent]; x3 = sd[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk_cnt++; if (got != 3) $display("FAIL b2b_count: got %0d results expected 3", got); else pass_cnt++;
        chk_cnt++; if (acc_cyc[1] - acc_cyc[0] != DATA_W + 2 || acc_cyc[2] - acc_cyc[1] != DATA_W + 2)
            $display("FAIL b2b_period: got %0d,%0d expected %0d", acc_cyc[1] - acc_cyc[0],
                     acc_cyc[2] - acc_cyc[1], DATA_W + 2);
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero();
        test_x0_neg();
        test_x3_one();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
